// File: rtl/fetch_controller.sv
// ----------------------------------------------------------------------------
// fetch_controller
//
// Instruction fetch sequencer for a 1024-word, byte-addressed instruction
// memory that is read combinationally. It holds the program counter, drives
// the memory address and presents registered instructions to decode over a
// valid/ready handshake. While the core is not running, the memory address
// port belongs to a boot loader that writes instruction words.
//
// Ports
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   start               one-cycle pulse: begin execution from RESET_PC
//   halt_req            stop fetching (moves RUN -> HALTED)
//   branch_taken        one-cycle redirect request
//   branch_target       redirect byte address
//   imem_addr           byte address to instruction memory
//   imem_rd             combinational read data from memory
//   imem_we, imem_wdata loader write path into memory
//   load_valid          loader has a word to write
//   load_addr/load_data loader byte address and word
//   load_ready          loader write accepted this cycle
//   instr, instr_pc     instruction to decode and its byte address
//   instr_valid         instr/instr_pc valid
//   instr_ready         decode accepts instr
//   running             high while in RUN
//   fault               sticky out-of-range fetch flag
//   fetch_count         number of instructions accepted by decode (wraps)
// ----------------------------------------------------------------------------
module fetch_controller #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 32,
    parameter int                MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rd,
    output logic              imem_we,
    output logic [DATA_W-1:0] imem_wdata,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              running,
    output logic              fault,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    // One bit wider than the address so MEM_WORDS*4 itself is representable.
    localparam int                MEM_BYTES_INT = MEM_WORDS * 4;
    localparam logic [ADDR_W:0]   MEM_BYTES     = MEM_BYTES_INT[ADDR_W:0];
    localparam logic [ADDR_W-1:0] WORD_MASK     = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP       = ADDR_W'(4);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                valid_q, valid_d;
    logic                fault_q, fault_d;
    logic [31:0]         count_q, count_d;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < MEM_BYTES;
    endfunction

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & WORD_MASK;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        count_d    = count_q;

        // Loader owns the memory port unless the core is running.
        imem_addr  = word_align(load_addr);
        imem_we    = load_valid && in_range(load_addr);
        imem_wdata = load_data;
        load_ready = 1'b1;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                    fault_d = 1'b0;
                    valid_d = 1'b0;
                end
            end

            S_RUN: begin
                load_ready = 1'b0;
                imem_we    = 1'b0;
                imem_addr  = pc_q;

                // A branch discards the in-flight instruction, so it is not
                // counted; halt outranks branch and lets the handshake count.
                if (valid_q && instr_ready && !(branch_taken && !halt_req))
                    count_d = count_q + 32'd1;

                if (halt_req) begin
                    state_d = S_HALTED;
                    valid_d = 1'b0;
                end else if (branch_taken) begin
                    pc_d    = word_align(branch_target);
                    valid_d = 1'b0;
                end else if (!valid_q || instr_ready) begin
                    if (!in_range(pc_q)) begin
                        fault_d = 1'b1;
                        state_d = S_HALTED;
                        valid_d = 1'b0;
                    end else begin
                        instr_d    = imem_rd;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + PC_STEP;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign running     = (state_q == S_RUN);
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [31:0] imem_rd;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic        load_valid;
    logic [15:0] load_addr;
    logic [31:0] load_data;
    logic        load_ready;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        running;
    logic        fault;
    logic [31:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Instruction memory (written only through the DUT) and the bench's own
    // record of what the loader was asked to write.
    logic [31:0] tb_mem  [0:1023] = '{default: 32'h0};
    logic [31:0] exp_mem [0:1023] = '{default: 32'h0};

    assign imem_rd = (imem_addr < 16'h1000) ? tb_mem[imem_addr[11:2]] : 32'hBAD0_0000;

    always @(posedge clk)
        if (imem_we) tb_mem[imem_addr[11:2]] <= imem_wdata;

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .halt_req     (halt_req),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_rd      (imem_rd),
        .imem_we      (imem_we),
        .imem_wdata   (imem_wdata),
        .load_valid   (load_valid),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .running      (running),
        .fault        (fault),
        .fetch_count  (fetch_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        start         = 1'b0;
        halt_req      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0;
        load_valid    = 1'b0;
        load_addr     = 16'h0;
        load_data     = 32'h0;
        instr_ready   = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] addr, input logic [31:0] data);
        load_valid = 1'b1;
        load_addr  = addr;
        load_data  = data;
        tick();
        load_valid = 1'b0;
        if (addr < 16'h1000) exp_mem[addr[11:2]] = data;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        #1;
        n_tests++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_instr: valid=%b instr=%h pc=%h, want 0/0/0", instr_valid, instr, instr_pc);
        end
        n_tests++;
        if (fault !== 1'b0 || fetch_count !== 32'h0 || running !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ctrl: fault=%b cnt=%0d run=%b lrdy=%b, want 0/0/0/1", fault, fetch_count, running, load_ready);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_run;
        logic [31:0] vals [4];
        vals[0] = 32'h20; vals[1] = 32'h21; vals[2] = 32'h31; vals[3] = 32'h05;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_addr  = 16'(i * 4);
            load_data  = vals[i];
            #1;
            n_tests++;
            if (load_ready !== 1'b1 || imem_we !== 1'b1) begin
                n_fail++;
                $display("FAIL load_accept[%0d]: load_ready=%b imem_we=%b, want 1/1", i, load_ready, imem_we);
            end
            tick();
            exp_mem[i] = vals[i];
        end
        load_valid = 1'b0;
        do_start();
        n_tests++;
        if (running !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 16'h0) begin
            n_fail++;
            $display("FAIL start_state: run=%b valid=%b addr=%h, want 1/0/0000", running, instr_valid, imem_addr);
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (instr_valid !== 1'b1 || instr !== vals[k] || instr_pc !== 16'(k * 4)) begin
                n_fail++;
                $display("FAIL run_seq[%0d]: valid=%b instr=%h pc=%h, want 1/%h/%h", k, instr_valid, instr, instr_pc, vals[k], 16'(k * 4));
            end
        end
        tick();
        n_tests++;
        if (fetch_count !== 32'd4) begin
            n_fail++;
            $display("FAIL run_count: fetch_count=%0d, want 4", fetch_count);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        do_reset();
        do_start();
        instr_ready = 1'b1;
        tick();
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || instr !== 32'h21 || instr_pc !== 16'h4) begin
            n_fail++;
            $display("FAIL bp_pre: valid=%b instr=%h pc=%h, want 1/00000021/0004", instr_valid, instr, instr_pc);
        end
        instr_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            n_tests++;
            if (instr_valid !== 1'b1 || instr !== 32'h21 || instr_pc !== 16'h4 || imem_addr !== 16'h8) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b instr=%h pc=%h addr=%h, want 1/00000021/0004/0008", s, instr_valid, instr, instr_pc, imem_addr);
            end
        end
        instr_ready = 1'b1;
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || instr !== 32'h31 || instr_pc !== 16'h8 || fetch_count !== 32'd2) begin
            n_fail++;
            $display("FAIL bp_resume: valid=%b instr=%h pc=%h cnt=%0d, want 1/00000031/0008/2", instr_valid, instr, instr_pc, fetch_count);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_branch;
        do_reset();
        do_start();
        instr_ready = 1'b1;
        tick();
        tick();
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h8) begin
            n_fail++;
            $display("FAIL br_pre: valid=%b pc=%h, want 1/0008", instr_valid, instr_pc);
        end
        branch_taken  = 1'b1;
        branch_target = 16'h0022;
        tick();
        branch_taken = 1'b0;
        n_tests++;
        if (instr_valid !== 1'b0 || imem_addr !== 16'h0020 || fetch_count !== 32'd2) begin
            n_fail++;
            $display("FAIL br_flush: valid=%b addr=%h cnt=%0d, want 0/0020/2", instr_valid, imem_addr, fetch_count);
        end
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0020 || instr !== exp_mem[8]) begin
            n_fail++;
            $display("FAIL br_target: valid=%b pc=%h instr=%h, want 1/0020/%h", instr_valid, instr_pc, instr, exp_mem[8]);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_loader_blocked;
        do_reset();
        do_start();
        instr_ready = 1'b1;
        load_valid  = 1'b1;
        load_addr   = 16'h0010;
        load_data   = 32'hDEAD_BEEF;
        #1;
        n_tests++;
        if (load_ready !== 1'b0 || imem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_blocked: load_ready=%b imem_we=%b, want 0/0", load_ready, imem_we);
        end
        tick();
        tick();
        n_tests++;
        if (tb_mem[4] !== exp_mem[4]) begin
            n_fail++;
            $display("FAIL ld_no_write: mem[0x10]=%h, want %h", tb_mem[4], exp_mem[4]);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        n_tests++;
        if (running !== 1'b0 || instr_valid !== 1'b0 || load_ready !== 1'b1 || imem_we !== 1'b1 || imem_addr !== 16'h0010) begin
            n_fail++;
            $display("FAIL ld_halted: run=%b valid=%b lrdy=%b we=%b addr=%h, want 0/0/1/1/0010", running, instr_valid, load_ready, imem_we, imem_addr);
        end
        tick();
        exp_mem[4] = 32'hDEAD_BEEF;
        n_tests++;
        if (tb_mem[4] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL ld_written: mem[0x10]=%h, want deadbeef", tb_mem[4]);
        end
        load_addr = 16'h0013;
        #1;
        n_tests++;
        if (imem_addr !== 16'h0010 || imem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_align: addr=%h we=%b, want 0010/1", imem_addr, imem_we);
        end
        load_addr = 16'h1004;
        #1;
        n_tests++;
        if (imem_we !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_range: we=%b lrdy=%b, want 0/1", imem_we, load_ready);
        end
        load_valid  = 1'b0;
        instr_ready = 1'b0;
    endtask

    task automatic test_fault;
        logic [15:0] last_pc;
        logic        seen;
        int          budget;
        do_reset();
        do_start();
        instr_ready = 1'b1;
        last_pc = 16'hFFFF;
        seen    = 1'b0;
        budget  = 0;
        while (!seen && budget < 1200) begin
            tick();
            budget++;
            if (instr_valid === 1'b1) last_pc = instr_pc;
            if (fault === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL fault_timeout: fault=%b after %0d cycles, want 1", fault, budget);
        end
        n_tests++;
        if (running !== 1'b0 || instr_valid !== 1'b0 || last_pc !== 16'h0FFC || fetch_count !== 32'd1024) begin
            n_fail++;
            $display("FAIL fault_state: run=%b valid=%b last_pc=%h cnt=%0d, want 0/0/0ffc/1024", running, instr_valid, last_pc, fetch_count);
        end
        do_start();
        n_tests++;
        if (fault !== 1'b0 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_clear: fault=%b run=%b, want 0/1", fault, running);
        end
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0) begin
            n_fail++;
            $display("FAIL fault_restart: valid=%b pc=%h, want 1/0000", instr_valid, instr_pc);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        do_reset();
        do_start();
        instr_ready = 1'b1;
        tick();
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h4 || fetch_count !== 32'd1) begin
            n_fail++;
            $display("FAIL ar_pre: valid=%b pc=%h cnt=%0d, want 1/0004/1", instr_valid, instr_pc, fetch_count);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 16'h0 || fetch_count !== 32'h0) begin
            n_fail++;
            $display("FAIL ar_data: valid=%b instr=%h pc=%h cnt=%0d, want 0/0/0/0", instr_valid, instr, instr_pc, fetch_count);
        end
        n_tests++;
        if (running !== 1'b0 || fault !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_ctrl: run=%b fault=%b lrdy=%b, want 0/0/1", running, fault, load_ready);
        end
        tick();
        reset = 1'b0;
        instr_ready = 1'b0;
        tick();
    endtask

    task automatic test_random;
        logic [15:0] exp_next;
        logic [31:0] exp_cnt;
        logic        v0, rdy, br;
        logic [15:0] p0, tgt;
        logic [31:0] i0;
        do_reset();
        for (int k = 0; k < 64; k++) load_word(16'(k * 4), $urandom);
        do_start();
        exp_next = 16'h0;
        exp_cnt  = 32'h0;
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom_range(0, 9) < 7);
            br  = ($urandom_range(0, 7) == 0);
            tgt = 16'($urandom_range(0, 16'h3FF));
            instr_ready   = rdy;
            branch_taken  = br;
            branch_target = tgt;
            v0 = instr_valid;
            p0 = instr_pc;
            i0 = instr;
            tick();
            if (v0 && rdy && !br) exp_cnt = exp_cnt + 1;
            if (br) begin
                exp_next = tgt & 16'hFFFC;
                n_tests++;
                if (instr_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_branch[%0d]: valid=%b, want 0", c, instr_valid);
                end
            end else if (v0 && !rdy) begin
                n_tests++;
                if (instr_valid !== 1'b1 || instr_pc !== p0 || instr !== i0) begin
                    n_fail++;
                    $display("FAIL rnd_hold[%0d]: valid=%b pc=%h instr=%h, want 1/%h/%h", c, instr_valid, instr_pc, instr, p0, i0);
                end
            end else begin
                if (v0) exp_next = p0 + 16'd4;
                n_tests++;
                if (instr_valid !== 1'b1 || instr_pc !== exp_next || instr !== exp_mem[exp_next[11:2]]) begin
                    n_fail++;
                    $display("FAIL rnd_fetch[%0d]: valid=%b pc=%h instr=%h, want 1/%h/%h", c, instr_valid, instr_pc, instr, exp_next, exp_mem[exp_next[11:2]]);
                end
            end
            n_tests++;
            if (fetch_count !== exp_cnt || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_count[%0d]: cnt=%0d fault=%b, want %0d/0", c, fetch_count, fault, exp_cnt);
            end
        end
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_run();
        test_backpressure();
        test_branch();
        test_loader_blocked();
        test_fault();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
